// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and a small window-decode helper.
// The downstream sync-to-count stage imports the same constants.
package vga_timing_pkg;

    localparam int COUNT_W       = 10;
    localparam int TOTAL_COLS    = 800;
    localparam int TOTAL_ROWS    = 525;
    localparam int ACTIVE_COLS   = 640;
    localparam int ACTIVE_ROWS   = 480;
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_WIDTH  = 96;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_WIDTH  = 2;

    // True when lo <= cnt < lo+width. The count is zero-extended to 32 bits
    // so that a window ending exactly at 1024 does not wrap.
    function automatic logic in_window(input logic [COUNT_W-1:0] cnt,
                                       input int                 lo,
                                       input int                 width);
        return (32'(cnt) >= 32'(lo)) && (32'(cnt) < 32'(lo + width));
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle: flags, porched syncs, counters and strobes.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic               o_HSync;
    logic               o_VSync;
    logic               o_HSync_Porch;
    logic               o_VSync_Porch;
    logic [COUNT_W-1:0] o_Col_Count;
    logic [COUNT_W-1:0] o_Row_Count;
    logic               o_Frame_Start;
    logic               o_Line_Start;

    modport master (
        output o_HSync, o_VSync, o_HSync_Porch, o_VSync_Porch,
               o_Col_Count, o_Row_Count, o_Frame_Start, o_Line_Start
    );

    modport slave (
        input  o_HSync, o_VSync, o_HSync_Porch, o_VSync_Porch,
               o_Col_Count, o_Row_Count, o_Frame_Start, o_Line_Start
    );

endinterface

// File: rtl/vga_wrap_counter.sv
// Modulo-N counter with synchronous clear and enable. count_nxt exposes the
// value the register will take so the parent can register decodes of it.
module vga_wrap_counter #(
    parameter int N = 800,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt,
    output logic         tc
);

    assign tc = (count == W'(N - 1));

    // Next value: clear wins, otherwise advance and wrap at N-1 when enabled.
    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (en) begin
            count_nxt = tc ? '0 : count + W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator. Every output is a register loaded from
// the counters' next state, so flags stay cycle-aligned with the counts.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int TOTAL_COLS_P    = TOTAL_COLS,
    parameter int TOTAL_ROWS_P    = TOTAL_ROWS,
    parameter int ACTIVE_COLS_P   = ACTIVE_COLS,
    parameter int ACTIVE_ROWS_P   = ACTIVE_ROWS,
    parameter int H_FRONT_PORCH_P = H_FRONT_PORCH,
    parameter int H_SYNC_WIDTH_P  = H_SYNC_WIDTH,
    parameter int V_FRONT_PORCH_P = V_FRONT_PORCH,
    parameter int V_SYNC_WIDTH_P  = V_SYNC_WIDTH
) (
    input  logic            i_Clk,
    input  logic            i_Rst_L,
    input  logic            i_Enable,
    vga_sync_gen_if.master  vid
);

    if (TOTAL_COLS_P > (1 << COUNT_W) || TOTAL_ROWS_P > (1 << COUNT_W)) begin : g_bad_total
        $error("vga_sync_gen: TOTAL_* exceeds counter range");
    end
    if (ACTIVE_COLS_P + H_FRONT_PORCH_P + H_SYNC_WIDTH_P > TOTAL_COLS_P ||
        ACTIVE_ROWS_P + V_FRONT_PORCH_P + V_SYNC_WIDTH_P > TOTAL_ROWS_P) begin : g_bad_fit
        $error("vga_sync_gen: active + porch + sync exceeds total");
    end
    if (TOTAL_COLS_P < 1 || TOTAL_ROWS_P < 1 || ACTIVE_COLS_P < 1 || ACTIVE_ROWS_P < 1 ||
        H_FRONT_PORCH_P < 1 || H_SYNC_WIDTH_P < 1 ||
        V_FRONT_PORCH_P < 1 || V_SYNC_WIDTH_P < 1) begin : g_bad_width
        $error("vga_sync_gen: all widths must be >= 1");
    end

    localparam int H_SYNC_START = ACTIVE_COLS_P + H_FRONT_PORCH_P;
    localparam int V_SYNC_START = ACTIVE_ROWS_P + V_FRONT_PORCH_P;

    logic               run;
    logic               col_tc;
    logic               row_tc;
    logic [COUNT_W-1:0] col_nxt;
    logic [COUNT_W-1:0] row_nxt;

    // The first enabled edge after idle only marks running; counts already
    // sit at 0,0, so advancing starts on the following edge.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            run <= 1'b0;
        end else begin
            run <= i_Enable;
        end
    end

    vga_wrap_counter #(.N(TOTAL_COLS_P), .W(COUNT_W)) u_col (
        .clk       (i_Clk),
        .rst_l     (i_Rst_L),
        .clr       (!i_Enable),
        .en        (run),
        .count     (vid.o_Col_Count),
        .count_nxt (col_nxt),
        .tc        (col_tc)
    );

    vga_wrap_counter #(.N(TOTAL_ROWS_P), .W(COUNT_W)) u_row (
        .clk       (i_Clk),
        .rst_l     (i_Rst_L),
        .clr       (!i_Enable),
        .en        (run && col_tc),
        .count     (vid.o_Row_Count),
        .count_nxt (row_nxt),
        .tc        (row_tc)
    );

    // Flags decoded from the counters' next state, forced idle on reset or
    // disable. Strobes fire on restart from idle or on the matching wrap.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L || !i_Enable) begin
            vid.o_HSync       <= 1'b0;
            vid.o_VSync       <= 1'b0;
            vid.o_HSync_Porch <= 1'b1;
            vid.o_VSync_Porch <= 1'b1;
            vid.o_Frame_Start <= 1'b0;
            vid.o_Line_Start  <= 1'b0;
        end else begin
            vid.o_HSync       <= 32'(col_nxt) < 32'(ACTIVE_COLS_P);
            vid.o_VSync       <= 32'(row_nxt) < 32'(ACTIVE_ROWS_P);
            vid.o_HSync_Porch <= !in_window(col_nxt, H_SYNC_START, H_SYNC_WIDTH_P);
            vid.o_VSync_Porch <= !in_window(row_nxt, V_SYNC_START, V_SYNC_WIDTH_P);
            vid.o_Frame_Start <= !run || (col_tc && row_tc);
            vid.o_Line_Start  <= !run || col_tc;
        end
    end

endmodule
